// File: rtl/out_channel_pkg.sv
// out_channel_pkg: shared word-width default and reader FSM state encoding
package out_channel_pkg;
  localparam int MEM_W_DEFAULT = 12;
  typedef enum logic {RUN, DONE} state_e;
endpackage

// File: rtl/channel_fifo.sv
// channel_fifo: N-word circular buffer; write/read strobes are pre-qualified by the caller, head is zero when empty
module channel_fifo #(
  parameter int W = 12,
  parameter int N = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write,
  input  logic [W-1:0]           data,
  input  logic                   read,
  output logic [W-1:0]           head,
  output logic [$clog2(N+1)-1:0] count
);
  localparam int PW = $clog2(N);
  localparam int CW = $clog2(N + 1);
  logic [W-1:0] mem_q [N];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    wr_ptr_d = write ? (wr_ptr_q == PW'(N - 1) ? '0 : wr_ptr_q + 1'b1) : wr_ptr_q;
    rd_ptr_d = read ? (rd_ptr_q == PW'(N - 1) ? '0 : rd_ptr_q + 1'b1) : rd_ptr_q;
    count_d  = count_q + CW'(write) - CW'(read);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clock) begin
    if (!reset && write) mem_q[wr_ptr_q] <= data;
  end
  assign head  = count_q != '0 ? mem_q[rd_ptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/out_channel_reader.sv
// out_channel_reader: buffers producer words (outValid/outData/outFull) for a consumer (rdValid/rdData/rdReady) and checks the first NCheck transfers against expected, reporting count/finished/success
module out_channel_reader
  import out_channel_pkg::*;
#(
  parameter int MemoryElementWidth = MEM_W_DEFAULT,
  parameter int NOut = 4,
  parameter int NCheck = 2
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             outValid,
  input  logic [MemoryElementWidth-1:0]    outData,
  output logic                             outFull,
  output logic                             rdValid,
  output logic [MemoryElementWidth-1:0]    rdData,
  input  logic                             rdReady,
  input  logic [NCheck*MemoryElementWidth-1:0] expected,
  output logic [$clog2(NOut+1)-1:0]        count,
  output logic                             finished,
  output logic                             success
);
  localparam int W  = MemoryElementWidth;
  localparam int IW = $clog2(NCheck + 1);
  state_e state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic mismatch_q, mismatch_d, overflow_q, overflow_d, extra_q, extra_d;
  logic wr, transfer, run;
  logic [W-1:0] exp_word;
  channel_fifo #(.W(W), .N(NOut)) u_fifo (
    .clock (clock),
    .reset (reset),
    .write (wr),
    .data  (outData),
    .read  (transfer),
    .head  (rdData),
    .count (count)
  );
  assign outFull  = count == ($clog2(NOut+1))'(NOut);
  assign rdValid  = count != '0;
  assign wr       = outValid && !outFull;
  assign transfer = rdValid && rdReady;
  assign run      = state_q == RUN;
  assign exp_word = expected[int'(idx_q)*W +: W];
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      idx_q      <= '0;
      mismatch_q <= 1'b0;
      overflow_q <= 1'b0;
      extra_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      mismatch_q <= mismatch_d;
      overflow_q <= overflow_d;
      extra_q    <= extra_d;
    end
  end
  always_comb begin
    state_d = run && (NCheck == 0 || (transfer && int'(idx_q) == NCheck - 1)) ? DONE : state_q;
  end
  always_comb begin
    idx_d      = transfer && run ? idx_q + 1'b1 : idx_q;
    mismatch_d = mismatch_q | (transfer && run && rdData != exp_word);
    overflow_d = overflow_q | (outValid && outFull);
    extra_d    = extra_q | (transfer && !run);
  end
  always_comb begin
    finished = state_q == DONE;
    success  = finished && !mismatch_q && !overflow_q && !extra_q;
  end
endmodule
